// File: rtl/mvu_apb_responder.sv
// APB completer standing in for the MVU control plane: register bank, wait states,
// PSLVERR on out-of-range accesses and a countdown job that raises mvu_irq_o.
module mvu_apb_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic                    sys_clk_i,
    input  logic                    rst_n_i,
    input  logic [ADDR_WIDTH-1:0]   paddr_i,
    input  logic                    psel_i,
    input  logic                    penable_i,
    input  logic                    pwrite_i,
    input  logic [DATA_WIDTH-1:0]   pwdata_i,
    input  logic [DATA_WIDTH/8-1:0] pstrb_i,
    output logic                    pready_o,
    output logic [DATA_WIDTH-1:0]   prdata_o,
    output logic                    pslverr_o,
    output logic                    mvu_irq_o
);
    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                 state_reg;
    logic [3:0]             wcnt_reg;
    logic                   busy_reg;
    logic                   done_reg;
    logic [DATA_WIDTH-1:0]  cnt_reg;
    logic [DATA_WIDTH-1:0]  regs [2:NUM_REGS-1];

    logic [IDX_W-1:0]       idx;
    logic                   out_of_range;
    logic                   ready;
    logic                   commit_wr;
    logic                   start_wr;
    logic                   done_clr;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic                   unused_addr_bits;

    assign idx              = paddr_i[IDX_W+1:2];
    assign out_of_range     = |paddr_i[ADDR_WIDTH-1:IDX_W+2];
    assign unused_addr_bits = ^paddr_i[1:0];

    assign ready     = (state_reg == ACCESS) && psel_i && penable_i && (wcnt_reg == 4'(WAIT_STATES));
    assign commit_wr = ready && pwrite_i && !out_of_range;
    assign start_wr  = commit_wr && (idx == '0) && pstrb_i[0] && pwdata_i[0];
    assign done_clr  = commit_wr && (idx == IDX_W'(1)) && pstrb_i[0] && pwdata_i[1];

    assign pready_o  = ready;
    assign pslverr_o = ready && out_of_range;
    assign prdata_o  = (ready && !out_of_range) ? rd_data : '0;
    assign mvu_irq_o = done_reg;

    // The setup cycle is observed from IDLE/SETUP, so ACCESS coincides with penable.
    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg <= IDLE;
            wcnt_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (psel_i && !penable_i) begin
                        state_reg <= ACCESS;
                        wcnt_reg  <= '0;
                    end
                end
                SETUP: begin
                    if (psel_i && !penable_i) begin
                        state_reg <= ACCESS;
                        wcnt_reg  <= '0;
                    end else if (!psel_i) begin
                        state_reg <= IDLE;
                    end
                end
                ACCESS: begin
                    if (!psel_i) begin
                        state_reg <= IDLE;
                    end else if (!penable_i) begin
                        wcnt_reg <= '0;
                    end else if (ready) begin
                        state_reg <= SETUP;
                    end else if (wcnt_reg < 4'(WAIT_STATES)) begin
                        wcnt_reg <= wcnt_reg + 4'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 2; gi < NUM_REGS; gi++) begin : g_reg
            always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    regs[gi] <= '0;
                end else if (commit_wr && (idx == IDX_W'(gi))) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (pstrb_i[b]) begin
                            regs[gi][b*8 +: 8] <= pwdata_i[b*8 +: 8];
                        end
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        rd_data = '0;
        if (idx == IDX_W'(1)) begin
            rd_data[1:0] = {done_reg, busy_reg};
        end
        for (int i = 2; i < NUM_REGS; i++) begin
            if (idx == IDX_W'(i)) begin
                rd_data = regs[i];
            end
        end
    end

    // Completion is evaluated after the W1C so a same-edge completion keeps DONE set.
    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
            cnt_reg  <= '0;
        end else begin
            if (done_clr) begin
                done_reg <= 1'b0;
            end
            if (busy_reg) begin
                if (cnt_reg == '0) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end else begin
                    cnt_reg <= cnt_reg - DATA_WIDTH'(1);
                end
            end else if (start_wr) begin
                cnt_reg  <= regs[2];
                busy_reg <= 1'b1;
                done_reg <= 1'b0;
            end
        end
    end
endmodule
